// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and constants used by the FP writeback path.
package riscv_pkg;

    localparam int unsigned FpWidth         = 64;
    localparam int unsigned FpWbStarveLimit = 4;

    typedef struct packed {
        logic stall;
        logic flush;
    } pipeline_ctrl_t;

    typedef struct packed {
        logic               valid;
        logic [4:0]         dest;
        logic [FpWidth-1:0] data;
    } fp_wb_req_t;

endpackage

// File: rtl/fp_wb_queue.sv
// Circular FIFO buffering results of the non-stallable pipelined FPU,
// with occupancy count and a sticky overflow flag.
module fp_wb_queue
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned DATA_WIDTH = FpWidth
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [4:0]                   i_push_dest,
    input  logic [DATA_WIDTH-1:0]        i_push_data,
    input  logic                         i_pop,
    output logic [4:0]                   o_head_dest,
    output logic [DATA_WIDTH-1:0]        o_head_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]            dest_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = i_pop && (count != '0);
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = i_push && (!full || do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
            if (i_push && !do_push)      overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            dest_mem[wr_ptr] <= i_push_dest;
            data_mem[wr_ptr] <= i_push_data;
        end
    end

    assign o_head_dest = dest_mem[rd_ptr];
    assign o_head_data = data_mem[rd_ptr];
    assign o_count     = count;
    assign o_overflow  = overflow;

endmodule

// File: rtl/fp_wb_arbiter.sv
// Sequences the single FP regfile write port between the pipelined-FPU queue
// and stallable requesters, with starvation override and a registered output.
module fp_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned DATA_WIDTH   = FpWidth,
    parameter int unsigned QDEPTH       = 2,
    parameter int unsigned STARVE_LIMIT = FpWbStarveLimit
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_stall,
    input  logic                          i_pipe_valid,
    input  logic [4:0]                    i_pipe_dest,
    input  logic [DATA_WIDTH-1:0]         i_pipe_data,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*5-1:0]          i_req_dest,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_wb_valid,
    output logic [4:0]                    o_wb_dest,
    output logic [DATA_WIDTH-1:0]         o_wb_data,
    output logic [$clog2(QDEPTH+1)-1:0]   o_q_count,
    output logic                          o_overflow
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned WW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [4:0]            q_dest;
    logic [DATA_WIDTH-1:0] q_data;
    logic [CW-1:0]         q_count;
    logic                  q_pop;

    logic [IW-1:0]         rr_ptr;
    logic [WW-1:0]         wait_cnt [NUM_REQ];
    logic [NUM_REQ-1:0]    grant;
    logic [IW-1:0]         win_idx;
    logic [IW-1:0]         rr_idx;
    logic                  req_win;
    logic [4:0]            win_dest;
    logic [DATA_WIDTH-1:0] win_data;

    logic                  wb_valid;
    logic [4:0]            wb_dest;
    logic [DATA_WIDTH-1:0] wb_data;

    fp_wb_queue #(
        .DEPTH      (QDEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_queue (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (i_pipe_valid),
        .i_push_dest (i_pipe_dest),
        .i_push_data (i_pipe_data),
        .i_pop       (q_pop),
        .o_head_dest (q_dest),
        .o_head_data (q_data),
        .o_count     (q_count),
        .o_overflow  (o_overflow)
    );

    // Descending loops so the last match (lowest index / nearest to rr_ptr) wins.
    always_comb begin
        grant   = '0;
        q_pop   = 1'b0;
        req_win = 1'b0;
        win_idx = '0;
        rr_idx  = '0;
        if (!i_stall) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (i_req_valid[k] && (wait_cnt[k] >= WW'(STARVE_LIMIT)) &&
                    (q_count <= CW'(QDEPTH - 2))) begin
                    req_win = 1'b1;
                    win_idx = IW'(k);
                end
            end
            if (!req_win) begin
                if (q_count != '0) begin
                    q_pop = 1'b1;
                end else begin
                    for (int i = NUM_REQ - 1; i >= 0; i--) begin
                        rr_idx = IW'((32'(rr_ptr) + i) % NUM_REQ);
                        if (i_req_valid[rr_idx]) begin
                            req_win = 1'b1;
                            win_idx = rr_idx;
                        end
                    end
                end
            end
            if (req_win) grant[win_idx] = 1'b1;
        end
    end

    always_comb begin
        win_dest = q_dest;
        win_data = q_data;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                win_dest = i_req_dest[k*5 +: 5];
                win_data = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr <= '0;
            for (int k = 0; k < NUM_REQ; k++) wait_cnt[k] <= '0;
        end else if (!i_stall) begin
            if (req_win) begin
                rr_ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!i_req_valid[k] || grant[k]) begin
                    wait_cnt[k] <= '0;
                end else if (wait_cnt[k] < WW'(STARVE_LIMIT)) begin
                    wait_cnt[k] <= wait_cnt[k] + WW'(1);
                end
            end
        end
    end

    // Held during stall; the regfile is gated by stall so the write lands once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wb_valid <= 1'b0;
            wb_dest  <= '0;
            wb_data  <= '0;
        end else if (!i_stall) begin
            wb_valid <= req_win || q_pop;
            if (req_win || q_pop) begin
                wb_dest <= win_dest;
                wb_data <= win_data;
            end
        end
    end

    assign o_req_ready = grant;
    assign o_wb_valid  = wb_valid;
    assign o_wb_dest   = wb_dest;
    assign o_wb_data   = wb_data;
    assign o_q_count   = q_count;

endmodule
